hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Pipeline controller driving the enable/flush side of the fetch/decode and decode/execute
//  pipeline registers. Detects load-use hazards against the instruction held in decode/execute.
//  Squashes wrong-path instructions after a taken branch and freezes the pipe during multi-cycle
//  data-memory accesses. Sits beside decode; its outputs go to PC, FD and DE register enables/flushes.
// PARAMETERS
//  BRANCH_PENALTY  2   cycles FD is flushed after a taken branch, including detect cycle (legal 1..3)
//  MEM_TIMEOUT     64  MEM_WAIT cycles before mem_timeout sets (legal 2..255)
//  CNT_W           16  width of performance counters
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      synchronous reset, active-high
//  rs_fd, rt_fd  in   4      source register addresses of instruction in decode
//  rs_used       in   1      decode instruction reads rs
//  rt_used       in   1      decode instruction reads rt
//  mem_read_de   in   1      instruction in DE is a load
//  reg_write_de  in   1      instruction in DE writes a register
//  write_reg_de  in   4      destination register of instruction in DE
//  branch_taken  in   1      branch resolved taken this cycle (PC target valid)
//  dmem_busy     in   1      data memory not ready; whole pipe must hold
//  pc_wen        out  1      PC update enable
//  fd_wen        out  1      FD register enable
//  fd_flush      out  1      FD register loads NOP
//  de_wen        out  1      DE register enable
//  de_flush      out  1      DE register loads bubble (all control 0)
//  em_wen        out  1      EX/MEM register enable
//  mem_timeout   out  1      sticky error: MEM_WAIT exceeded MEM_TIMEOUT
//  stall_cycles  out  CNT_W  load-use + memory stall count
//  flush_cycles  out  CNT_W  branch flush count
// BEHAVIOUR
//  - States: RUN, LOAD_STALL, FLUSH, MEM_WAIT. Reset -> RUN, flush_cnt=0, wait_cnt=0, ret_state=RUN.
//  - While rst=1, outputs are forced combinationally: all *_wen=0, fd_flush=de_flush=1,
//    mem_timeout=0, counters=0.
//  - Default outputs (not in rst): all *_wen=1, flushes=0. Outputs are combinational from state+inputs.
//  - Event priority per cycle: dmem_busy > branch_taken > load-use.
//  - load_use = mem_read_de & reg_write_de & (write_reg_de!=0) &
//    ((rs_used & rs_fd==write_reg_de) | (rt_used & rt_fd==write_reg_de)).
//  - RUN:
//    - dmem_busy: all *_wen=0; ret_state<=RUN; wait_cnt<=1; -> MEM_WAIT.
//    - branch_taken: fd_flush=de_flush=1, pc_wen=1.
//      If BRANCH_PENALTY>1, flush_cnt<=BRANCH_PENALTY-1 and -> FLUSH; else stay in RUN.
//    - load_use: pc_wen=fd_wen=0, de_flush=1; -> LOAD_STALL.
//  - LOAD_STALL (exactly 1 cycle): default outputs; load-use not checked; -> RUN.
//    dmem_busy/branch_taken are handled as in RUN.
//  - FLUSH: fd_flush=1; flush_cnt decrements; -> RUN when flush_cnt==1.
//    branch_taken restarts flush_cnt at BRANCH_PENALTY-1.
//    dmem_busy: freeze (all *_wen=0, flush_cnt held), ret_state<=FLUSH, -> MEM_WAIT.
//  - MEM_WAIT: all *_wen=0, flushes=0 while dmem_busy; wait_cnt saturates at MEM_TIMEOUT.
//    When wait_cnt==MEM_TIMEOUT with dmem_busy=1, mem_timeout<=1 (cleared only by rst).
//    Release cycle (dmem_busy=0): outputs per ret_state, with branch/load-use detection suppressed;
//    next state = ret_state; wait_cnt<=0.
//  - Reset mid-operation returns to RUN the next edge regardless of state or counters.
// CONFIGURATION
//  - HAZARD_PERF_EN defined: stall_cycles +1 each cycle with pc_wen=0 (not in rst);
//    flush_cycles +1 each cycle with fd_flush=1 (not in rst). Both saturate at all-ones.
//  - HAZARD_PERF_EN undefined: no counter logic; stall_cycles and flush_cycles tied to 0.
// TESTING
//  1 load-use: mem_read_de=1, reg_write_de=1, write_reg_de=3, rs_fd=3, rs_used=1
//    -> one cycle pc_wen=0, fd_wen=0, de_flush=1; next cycle all enables 1, state RUN.
//  2 write_reg_de=0 with matching rs_fd=0 -> no stall.
//    Same case with rs_used=0, rt_fd=3, rt_used=0 -> no stall.
//  3 branch_taken pulse, BRANCH_PENALTY=2 -> fd_flush=1 for 2 cycles; de_flush=1 only first;
//    pc_wen=1 throughout.
//  4 dmem_busy high 5 cycles during FLUSH -> enables 0 for 5 cycles; release cycle fd_flush=1;
//    back in RUN next.
//  5 dmem_busy held 70 cycles, MEM_TIMEOUT=64 -> mem_timeout rises after cycle 64, stays 1 until rst.
//  6 rst asserted in MEM_WAIT -> outputs forced per rst rule; RUN after release.
//    With HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// ============================================================================
// hazard_control_unit
// ----------------------------------------------------------------------------
// Pipeline hazard controller that sits beside decode. It drives the enables
// and flushes of the PC, FD, DE and EX/MEM pipeline registers. It handles
// three kinds of event:
//   - load-use hazards against the instruction held in decode/execute,
//   - squashing wrong-path instructions after a taken branch,
//   - freezing the pipe during multi-cycle data-memory accesses.
// Priority within one cycle is dmem_busy > branch_taken > load-use.
//
// Parameters:
//   BRANCH_PENALTY  cycles FD is flushed after a taken branch, detect cycle
//                   included (1..3)
//   MEM_TIMEOUT     MEM_WAIT cycles before mem_timeout sets (2..255)
//   CNT_W           width of the performance counters
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   rs_fd, rt_fd             source registers of the decode instruction
//   rs_used, rt_used         decode instruction actually reads rs / rt
//   mem_read_de              DE instruction is a load
//   reg_write_de             DE instruction writes a register
//   write_reg_de             destination register of the DE instruction
//   branch_taken             branch resolved taken this cycle
//   dmem_busy                data memory not ready; whole pipe holds
//   pc_wen, fd_wen, de_wen,
//   em_wen                   pipeline register enables
//   fd_flush, de_flush       load NOP / bubble into FD / DE
//   mem_timeout              sticky: memory wait exceeded MEM_TIMEOUT
//   stall_cycles             count of cycles with pc_wen=0
//   flush_cycles             count of cycles with fd_flush=1
//
// Build option: define HAZARD_PERF_EN to build the performance counters.
// Without it, stall_cycles and flush_cycles are tied to zero.
// ============================================================================
module hazard_control_unit #(
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       rs_fd,
    input  logic [3:0]       rt_fd,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic             mem_read_de,
    input  logic             reg_write_de,
    input  logic [3:0]       write_reg_de,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_wen,
    output logic             fd_wen,
    output logic             fd_flush,
    output logic             de_wen,
    output logic             de_flush,
    output logic             em_wen,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_e;

    localparam logic [1:0] FLUSH_RELOAD = 2'(BRANCH_PENALTY - 1);
    localparam logic [7:0] TIMEOUT_VAL  = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    state_e     ret_state_q, ret_state_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic pc_wen_c, fd_wen_c, de_wen_c, em_wen_c;
    logic fd_flush_c, de_flush_c;
    logic load_use;

    // Register 0 is hard-wired zero, so a load targeting it creates no hazard.
    assign load_use = mem_read_de & reg_write_de & (write_reg_de != 4'd0) &
                      ((rs_used & (rs_fd == write_reg_de)) |
                       (rt_used & (rt_fd == write_reg_de)));

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        pc_wen_c      = 1'b1;
        fd_wen_c      = 1'b1;
        de_wen_c      = 1'b1;
        em_wen_c      = 1'b1;
        fd_flush_c    = 1'b0;
        de_flush_c    = 1'b0;
        state_d       = state_q;
        ret_state_d   = ret_state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;

        unique case (state_q)
            RUN, LOAD_STALL: begin
                state_d = RUN;
                if (dmem_busy) begin
                    pc_wen_c    = 1'b0;
                    fd_wen_c    = 1'b0;
                    de_wen_c    = 1'b0;
                    em_wen_c    = 1'b0;
                    ret_state_d = RUN;
                    wait_cnt_d  = 8'd1;
                    state_d     = MEM_WAIT;
                end else if (branch_taken) begin
                    fd_flush_c = 1'b1;
                    de_flush_c = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        flush_cnt_d = FLUSH_RELOAD;
                        state_d     = FLUSH;
                    end
                end else if (load_use && (state_q == RUN)) begin
                    // Hold PC and FD and inject a bubble so the load can complete.
                    // LOAD_STALL never re-detects, so the stall lasts exactly one cycle.
                    pc_wen_c   = 1'b0;
                    fd_wen_c   = 1'b0;
                    de_flush_c = 1'b1;
                    state_d    = LOAD_STALL;
                end
            end

            FLUSH: begin
                if (dmem_busy) begin
                    // Freeze: the flush count is held and resumes on release.
                    pc_wen_c    = 1'b0;
                    fd_wen_c    = 1'b0;
                    de_wen_c    = 1'b0;
                    em_wen_c    = 1'b0;
                    ret_state_d = FLUSH;
                    wait_cnt_d  = 8'd1;
                    state_d     = MEM_WAIT;
                end else if (branch_taken) begin
                    fd_flush_c  = 1'b1;
                    de_flush_c  = 1'b1;
                    flush_cnt_d = FLUSH_RELOAD;
                end else begin
                    fd_flush_c  = 1'b1;
                    flush_cnt_d = flush_cnt_q - 2'd1;
                    if (flush_cnt_q == 2'd1) begin
                        state_d = RUN;
                    end
                end
            end

            MEM_WAIT: begin
                if (dmem_busy) begin
                    pc_wen_c = 1'b0;
                    fd_wen_c = 1'b0;
                    de_wen_c = 1'b0;
                    em_wen_c = 1'b0;
                    if (wait_cnt_q < TIMEOUT_VAL) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                    if (wait_cnt_q == TIMEOUT_VAL) begin
                        mem_timeout_d = 1'b1;
                    end
                end else begin
                    // The release cycle behaves like the interrupted state with
                    // hazard detection suppressed. An interrupted flush performs
                    // its pending flush cycle here, so a final one ends in RUN.
                    wait_cnt_d = 8'd0;
                    state_d    = ret_state_q;
                    if (ret_state_q == FLUSH) begin
                        fd_flush_c  = 1'b1;
                        flush_cnt_d = flush_cnt_q - 2'd1;
                        if (flush_cnt_q == 2'd1) begin
                            state_d = RUN;
                        end
                    end
                end
            end

            default: state_d = RUN;
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            ret_state_q   <= RUN;
            flush_cnt_q   <= 2'd0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_state_q   <= ret_state_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Reset overrides the outputs combinationally, so the pipe is held and
    // flushed from the very first reset cycle.
    assign pc_wen      = ~rst & pc_wen_c;
    assign fd_wen      = ~rst & fd_wen_c;
    assign de_wen      = ~rst & de_wen_c;
    assign em_wen      = ~rst & em_wen_c;
    assign fd_flush    =  rst | fd_flush_c;
    assign de_flush    =  rst | de_flush_c;
    assign mem_timeout = ~rst & mem_timeout_q;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_tot_q;

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_tot_q <= '0;
        end else begin
            if (!pc_wen_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (fd_flush_c && (flush_tot_q != '1)) begin
                flush_tot_q <= flush_tot_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = rst ? '0 : stall_cnt_q;
    assign flush_cycles = rst ? '0 : flush_tot_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// tb_hazard_control_unit
// ----------------------------------------------------------------------------
// Directed testbench for hazard_control_unit with the default parameters
// (BRANCH_PENALTY=2, MEM_TIMEOUT=64). Inputs are driven 1 time unit after the
// rising edge, and outputs are sampled on the falling edge of the same cycle.
// Output vector order: {pc_wen, fd_wen, de_wen, em_wen, fd_flush, de_flush}.
// ============================================================================
module tb_hazard_control_unit;

    localparam logic [5:0] O_NORM  = 6'b1111_00;
    localparam logic [5:0] O_LU    = 6'b0011_01;
    localparam logic [5:0] O_BR    = 6'b1111_11;
    localparam logic [5:0] O_FL    = 6'b1111_10;
    localparam logic [5:0] O_HOLD  = 6'b0000_00;
    localparam logic [5:0] O_RST   = 6'b0000_11;

`ifdef HAZARD_PERF_EN
    localparam logic [15:0] EXP_STALL = 16'd1;
    localparam logic [15:0] EXP_FLUSH = 16'd2;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
    localparam logic [15:0] EXP_FLUSH = 16'd0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  rs_fd, rt_fd, write_reg_de;
    logic        rs_used, rt_used, mem_read_de, reg_write_de;
    logic        branch_taken, dmem_busy;
    logic        pc_wen, fd_wen, fd_flush, de_wen, de_flush, em_wen;
    logic        mem_timeout;
    logic [15:0] stall_cycles, flush_cycles;
    logic [5:0]  outs;

    int vectors     = 0;
    int miscompares = 0;

    assign outs = {pc_wen, fd_wen, de_wen, em_wen, fd_flush, de_flush};

    hazard_control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rs_fd        (rs_fd),
        .rt_fd        (rt_fd),
        .rs_used      (rs_used),
        .rt_used      (rt_used),
        .mem_read_de  (mem_read_de),
        .reg_write_de (reg_write_de),
        .write_reg_de (write_reg_de),
        .branch_taken (branch_taken),
        .dmem_busy    (dmem_busy),
        .pc_wen       (pc_wen),
        .fd_wen       (fd_wen),
        .fd_flush     (fd_flush),
        .de_wen       (de_wen),
        .de_flush     (de_flush),
        .em_wen       (em_wen),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rs_fd = 4'd0; rt_fd = 4'd0; write_reg_de = 4'd0;
        rs_used = 1'b0; rt_used = 1'b0;
        mem_read_de = 1'b0; reg_write_de = 1'b0;
        branch_taken = 1'b0; dmem_busy = 1'b0;
    endtask

    // Load in DE writing r3, decode reads r3 through rs.
    task automatic load_use_inputs();
        mem_read_de = 1'b1; reg_write_de = 1'b1; write_reg_de = 4'd3;
        rs_fd = 4'd3; rs_used = 1'b1;
    endtask

    task automatic test_reset();
        tick(); rst = 1'b1; idle_inputs(); sample();
        vectors++;
        if (outs !== O_RST) begin miscompares++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RST); end
        vectors++;
        if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
        vectors++;
        if (stall_cycles !== 16'd0 || flush_cycles !== 16'd0) begin
            miscompares++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_cycles);
        end
        tick(); rst = 1'b0; sample();
        vectors++;
        if (outs !== O_NORM) begin miscompares++; $display("FAIL post_reset_idle got=%b exp=%b", outs, O_NORM); end
    endtask

    task automatic test_load_use();
        tick(); load_use_inputs(); sample();
        vectors++;
        if (outs !== O_LU) begin miscompares++; $display("FAIL lu_rs_stall got=%b exp=%b", outs, O_LU); end
        tick(); sample();  // LOAD_STALL ignores the still-present hazard
        vectors++;
        if (outs !== O_NORM) begin miscompares++; $display("FAIL lu_stall_release got=%b exp=%b", outs, O_NORM); end
        tick(); sample();  // back in RUN: same hazard detected again
        vectors++;
        if (outs !== O_LU) begin miscompares++; $display("FAIL lu_back_in_run got=%b exp=%b", outs, O_LU); end
        tick(); idle_inputs();
        mem_read_de = 1'b1; reg_write_de = 1'b1; write_reg_de = 4'd5;
        rt_fd = 4'd5; rt_used = 1'b1; sample();  // LOAD_STALL cycle
        tick(); sample();
        vectors++;
        if (outs !== O_LU) begin miscompares++; $display("FAIL lu_rt_stall got=%b exp=%b", outs, O_LU); end
        tick(); idle_inputs();
        reg_write_de = 1'b1; write_reg_de = 4'd3; rs_fd = 4'd3; rs_used = 1'b1; sample();
        tick(); sample();
        vectors++;
        if (outs !== O_NORM) begin miscompares++; $display("FAIL lu_not_a_load got=%b exp=%b", outs, O_NORM); end
        tick(); idle_inputs(); sample();
    endtask

    task automatic test_no_stall();
        tick(); idle_inputs();
        mem_read_de = 1'b1; reg_write_de = 1'b1; write_reg_de = 4'd0;
        rs_fd = 4'd0; rs_used = 1'b1; sample();
        vectors++;
        if (outs !== O_NORM) begin miscompares++; $display("FAIL ns_reg_zero got=%b exp=%b", outs, O_NORM); end
        tick(); write_reg_de = 4'd3; rs_fd = 4'd3; rs_used = 1'b0;
        rt_fd = 4'd3; rt_used = 1'b0; sample();
        vectors++;
        if (outs !== O_NORM) begin miscompares++; $display("FAIL ns_sources_unused got=%b exp=%b", outs, O_NORM); end
        tick(); idle_inputs(); sample();
    endtask

    task automatic test_branch();
        tick(); branch_taken = 1'b1; sample();
        vectors++;
        if (outs !== O_BR) begin miscompares++; $display("FAIL br_detect got=%b exp=%b", outs, O_BR); end
        tick(); branch_taken = 1'b0; sample();
        vectors++;
        if (outs !== O_FL) begin miscompares++; $display("FAIL br_flush2 got=%b exp=%b", outs, O_FL); end
        tick(); sample();
        vectors++;
        if (outs !== O_NORM) begin miscompares++; $display("FAIL br_done got=%b exp=%b", outs, O_NORM); end
    endtask

    task automatic test_branch_over_load_use();
        tick(); load_use_inputs(); branch_taken = 1'b1; sample();
        vectors++;
        if (outs !== O_BR) begin miscompares++; $display("FAIL prio_br_wins got=%b exp=%b", outs, O_BR); end
        tick(); branch_taken = 1'b0; sample();
        vectors++;
        if (outs !== O_FL) begin miscompares++; $display("FAIL prio_flush_no_lu got=%b exp=%b", outs, O_FL); end
        tick(); sample();
        vectors++;
        if (outs !== O_LU) begin miscompares++; $display("FAIL prio_lu_after got=%b exp=%b", outs, O_LU); end
        tick(); idle_inputs(); sample();
    endtask

    task automatic test_flush_mem_wait();
        tick(); branch_taken = 1'b1; sample();
        tick(); branch_taken = 1'b0; dmem_busy = 1'b1; sample();
        vectors++;
        if (outs[5:2] !== 4'b0000) begin miscompares++; $display("FAIL fm_freeze_wen got=%b exp=0000", outs[5:2]); end
        for (int i = 2; i <= 5; i++) begin
            tick(); sample();
            vectors++;
            if (outs !== O_HOLD) begin miscompares++; $display("FAIL fm_hold_%0d got=%b exp=%b", i, outs, O_HOLD); end
        end
        tick(); dmem_busy = 1'b0; sample();
        vectors++;
        if (outs !== O_FL) begin miscompares++; $display("FAIL fm_release got=%b exp=%b", outs, O_FL); end
        tick(); sample();
        vectors++;
        if (outs !== O_NORM) begin miscompares++; $display("FAIL fm_run got=%b exp=%b", outs, O_NORM); end
        tick(); load_use_inputs(); sample();
        vectors++;
        if (outs !== O_LU) begin miscompares++; $display("FAIL fm_run_lu got=%b exp=%b", outs, O_LU); end
        tick(); idle_inputs(); sample();
    endtask

    task automatic test_mem_release();
        tick(); dmem_busy = 1'b1; branch_taken = 1'b1; sample();
        vectors++;
        if (outs !== O_HOLD) begin miscompares++; $display("FAIL mr_busy_wins got=%b exp=%b", outs, O_HOLD); end
        tick(); branch_taken = 1'b0; sample();
        vectors++;
        if (outs !== O_HOLD) begin miscompares++; $display("FAIL mr_wait got=%b exp=%b", outs, O_HOLD); end
        tick(); dmem_busy = 1'b0; load_use_inputs(); sample();
        vectors++;
        if (outs !== O_NORM) begin miscompares++; $display("FAIL mr_release_suppress got=%b exp=%b", outs, O_NORM); end
        tick(); sample();
        vectors++;
        if (outs !== O_LU) begin miscompares++; $display("FAIL mr_lu_after got=%b exp=%b", outs, O_LU); end
        tick(); idle_inputs(); sample();
    endtask

    task automatic test_timeout();
        for (int n = 1; n <= 70; n++) begin
            tick(); dmem_busy = 1'b1; sample();
            if (n == 64) begin
                vectors++;
                if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL to_early got=%b exp=0", mem_timeout); end
            end
            if (n == 67) begin
                vectors++;
                if (mem_timeout !== 1'b1) begin miscompares++; $display("FAIL to_set got=%b exp=1", mem_timeout); end
            end
            if (n == 70) begin
                vectors++;
                if (outs !== O_HOLD) begin miscompares++; $display("FAIL to_hold got=%b exp=%b", outs, O_HOLD); end
            end
        end
        tick(); dmem_busy = 1'b0; sample();
        vectors++;
        if (outs !== O_NORM) begin miscompares++; $display("FAIL to_release got=%b exp=%b", outs, O_NORM); end
        tick(); sample();
        vectors++;
        if (mem_timeout !== 1'b1) begin miscompares++; $display("FAIL to_sticky got=%b exp=1", mem_timeout); end
    endtask

    task automatic test_reset_mid_wait();
        tick(); dmem_busy = 1'b1; sample();
        tick(); sample();
        tick(); rst = 1'b1; sample();
        vectors++;
        if (outs !== O_RST) begin miscompares++; $display("FAIL rm_outs got=%b exp=%b", outs, O_RST); end
        vectors++;
        if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL rm_timeout got=%b exp=0", mem_timeout); end
        vectors++;
        if (stall_cycles !== 16'd0 || flush_cycles !== 16'd0) begin
            miscompares++; $display("FAIL rm_counters got=%0d/%0d exp=0/0", stall_cycles, flush_cycles);
        end
        tick(); rst = 1'b0; idle_inputs(); sample();
        vectors++;
        if (outs !== O_NORM) begin miscompares++; $display("FAIL rm_run got=%b exp=%b", outs, O_NORM); end
        vectors++;
        if (mem_timeout !== 1'b0) begin miscompares++; $display("FAIL rm_timeout_clear got=%b exp=0", mem_timeout); end
        tick(); load_use_inputs(); sample();
        vectors++;
        if (outs !== O_LU) begin miscompares++; $display("FAIL rm_lu got=%b exp=%b", outs, O_LU); end
        tick(); idle_inputs(); sample();
    endtask

    // From a clean reset: one load-use stall, then one branch (2 flush cycles).
    task automatic test_perf_counters();
        tick(); rst = 1'b1; idle_inputs(); sample();
        tick(); rst = 1'b0; load_use_inputs(); sample();
        tick(); idle_inputs(); sample();
        tick(); branch_taken = 1'b1; sample();
        tick(); branch_taken = 1'b0; sample();
        tick(); sample();
        vectors++;
        if (stall_cycles !== EXP_STALL) begin
            miscompares++; $display("FAIL perf_stall got=%0d exp=%0d", stall_cycles, EXP_STALL);
        end
        vectors++;
        if (flush_cycles !== EXP_FLUSH) begin
            miscompares++; $display("FAIL perf_flush got=%0d exp=%0d", flush_cycles, EXP_FLUSH);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_branch_over_load_use();
        test_flush_mem_wait();
        test_mem_release();
        test_timeout();
        test_reset_mid_wait();
        test_perf_counters();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
